dac_spi_responder: RTL and testbench

- Synthesizable model of the LTC2624-style 4-channel, 12-bit SPI DAC. It is the responder end of the DacSpi master link.
- It oversamples SPI_SCK, DAC_CS, SPI_MOSI and DAC_CLR on CLK50MHZ and captures 32-bit frames.
- It decodes command and address, then updates per-channel input and DAC registers.
- It shifts the previous frame back out on DAC_OUT, so the master's readback path can be closed in simulation or in a loopback build.

---
 rtl/dac_spi_responder_if.sv | 13 +
 rtl/dac_spi_responder.sv | 180 ++++++++++++++++++
 tb/tb_dac_spi_responder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_responder_if.sv
// SPI pin bundle between the DacSpi master and the LTC2624-style responder.
interface dac_spi_responder_if;
  logic SPI_SCK;
  logic DAC_CS;
  logic SPI_MOSI;
  logic DAC_CLR;
  logic DAC_OUT;

  modport master (output SPI_SCK, output DAC_CS, output SPI_MOSI, output DAC_CLR,
                  input DAC_OUT);
  modport slave (input SPI_SCK, input DAC_CS, input SPI_MOSI, input DAC_CLR,
                 output DAC_OUT);
endinterface

// File: rtl/dac_spi_responder.sv
// LTC2624-style 4-channel 12-bit SPI DAC responder. Oversamples the SPI pins
// on CLK50MHZ, captures 32-bit frames, decodes command/address into input and
// DAC registers, and shifts the previous frame back out on DAC_OUT.
module dac_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 32
) (
  input  logic                CLK50MHZ,
  input  logic                RST,
  dac_spi_responder_if.slave  spi,
  output logic [47:0]         dac_value,
  output logic [3:0]          dac_powerdown,
  output logic [31:0]         last_frame,
  output logic                frame_done,
  output logic                frame_err
);

  localparam int CW = $clog2(FRAME_BITS + 2);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // SCK and CS keep one extra flop so edges compare the last two synced values
  logic [SYNC_STAGES:0]   sck_sh;
  logic [SYNC_STAGES:0]   cs_sh;
  logic [SYNC_STAGES-1:0] mosi_sh;
  logic [SYNC_STAGES-1:0] clr_sh;
  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s, clr_s;

  state_t state, state_nx;
  logic shift_en, out_en, cnt_clr, commit, abort;

  logic [CW-1:0]     bit_cnt;
  logic [31:0]       sreg;
  logic              dac_out;
  logic [3:0][11:0]  inreg, inreg_nx;
  logic [3:0][11:0]  dac, dac_nx;
  logic [3:0]        pd, pd_nx, sel;
  logic [3:0]        cmd, addr;
  logic [11:0]       data;

  // Pin synchronizers, reset to the idle pin levels
  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      sck_sh  <= '0;
      cs_sh   <= '1;
      mosi_sh <= '0;
      clr_sh  <= '1;
    end else begin
      sck_sh  <= {sck_sh[SYNC_STAGES-1:0], spi.SPI_SCK};
      cs_sh   <= {cs_sh[SYNC_STAGES-1:0], spi.DAC_CS};
      mosi_sh <= {mosi_sh[SYNC_STAGES-2:0], spi.SPI_MOSI};
      clr_sh  <= {clr_sh[SYNC_STAGES-2:0], spi.DAC_CLR};
    end
  end

  assign sck_rise = sck_sh[SYNC_STAGES-1] & ~sck_sh[SYNC_STAGES];
  assign sck_fall = ~sck_sh[SYNC_STAGES-1] & sck_sh[SYNC_STAGES];
  assign cs_rise  = cs_sh[SYNC_STAGES-1] & ~cs_sh[SYNC_STAGES];
  assign cs_fall  = ~cs_sh[SYNC_STAGES-1] & cs_sh[SYNC_STAGES];
  assign mosi_s   = mosi_sh[SYNC_STAGES-1];
  assign clr_s    = clr_sh[SYNC_STAGES-1];

  // Frame state register
  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state; CS edges win over a coincident SCK edge
  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    out_en   = 1'b0;
    cnt_clr  = 1'b0;
    commit   = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nx = SHIFT;
          cnt_clr  = 1'b1;
          shift_en = sck_rise;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nx = IDLE;
          if (bit_cnt == CW'(FRAME_BITS)) commit = 1'b1;
          else                            abort  = 1'b1;
        end else begin
          shift_en = sck_rise;
          out_en   = sck_fall;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cmd  = sreg[23:20];
  assign addr = sreg[19:16];
  assign data = sreg[15:4];

  // Command decode; an active clear overrides any write from the frame
  always_comb begin
    sel      = 4'b0000;
    inreg_nx = inreg;
    dac_nx   = dac;
    pd_nx    = pd;
    if (addr == 4'hF)      sel = 4'hF;
    else if (addr < 4'd4)  sel = 4'b0001 << addr[1:0];
    if (commit && clr_s) begin
      case (cmd)
        4'b0000: begin
          for (int n = 0; n < 4; n++) if (sel[n]) inreg_nx[n] = data;
        end
        4'b0001: begin
          for (int n = 0; n < 4; n++)
            if (sel[n]) begin
              dac_nx[n] = inreg[n];
              pd_nx[n]  = 1'b0;
            end
        end
        4'b0010: begin
          for (int n = 0; n < 4; n++) if (sel[n]) inreg_nx[n] = data;
          dac_nx = inreg_nx;
          pd_nx  = 4'b0000;
        end
        4'b0011: begin
          for (int n = 0; n < 4; n++)
            if (sel[n]) begin
              inreg_nx[n] = data;
              dac_nx[n]   = data;
              pd_nx[n]    = 1'b0;
            end
        end
        4'b0100: begin
          for (int n = 0; n < 4; n++) if (sel[n]) pd_nx[n] = 1'b1;
        end
        default: ;
      endcase
    end
    if (!clr_s) begin
      inreg_nx = '0;
      dac_nx   = '0;
    end
  end

  // Shift register, bit counter, readback pin, frame commit and channel registers
  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      bit_cnt    <= '0;
      sreg       <= '0;
      dac_out    <= 1'b0;
      last_frame <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      inreg      <= '0;
      dac        <= '0;
      pd         <= '0;
    end else begin
      if (cnt_clr)
        bit_cnt <= shift_en ? CW'(1) : '0;
      else if (shift_en && bit_cnt != CW'(FRAME_BITS + 1))
        bit_cnt <= bit_cnt + CW'(1);
      if (shift_en) sreg <= {sreg[30:0], mosi_s};
      if (state == IDLE || out_en) dac_out <= sreg[31];
      if (commit) last_frame <= sreg;
      frame_done <= commit;
      frame_err  <= abort;
      inreg      <= inreg_nx;
      dac        <= dac_nx;
      pd         <= pd_nx;
    end
  end

  assign dac_value     = dac;
  assign dac_powerdown = pd;
  assign spi.DAC_OUT   = dac_out;

endmodule

// File: tb/tb_dac_spi_responder.sv
// Bench for dac_spi_responder: directed frames from the test plan followed by
// random frames, all checked against a behavioural DAC model.
module tb_dac_spi_responder;

  localparam int H = 6;  // clock cycles per SCK half period

  logic clk = 1'b0;
  logic rst;
  logic [47:0] dac_value;
  logic [3:0]  dac_powerdown;
  logic [31:0] last_frame;
  logic        frame_done, frame_err;

  dac_spi_responder_if bus ();

  dac_spi_responder #(.SYNC_STAGES(2), .FRAME_BITS(32)) dut (
    .CLK50MHZ      (clk),
    .RST           (rst),
    .spi           (bus),
    .dac_value     (dac_value),
    .dac_powerdown (dac_powerdown),
    .last_frame    (last_frame),
    .frame_done    (frame_done),
    .frame_err     (frame_err)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  // Behavioural model state
  logic [11:0] inreg_m [4];
  logic [11:0] dac_m [4];
  logic [3:0]  pd_m;
  logic [31:0] last_m;
  logic [31:0] sreg_m;
  logic        clr_m;
  int          exp_done;
  int          exp_err;

  always @(negedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err)  err_cnt  <= err_cnt + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] dac_pack();
    return {dac_m[3], dac_m[2], dac_m[1], dac_m[0]};
  endfunction

  task automatic model_clear_regs();
    for (int c = 0; c < 4; c++) begin
      inreg_m[c] = 12'h000;
      dac_m[c]   = 12'h000;
    end
  endtask

  task automatic model_reset();
    model_clear_regs();
    pd_m   = 4'h0;
    last_m = 32'h0;
    sreg_m = 32'h0;
  endtask

  // What the DAC does with a correctly sized frame
  task automatic model_apply(input logic [31:0] f);
    int cmd, adr;
    logic [11:0] d;
    cmd = int'(f[23:20]);
    adr = int'(f[19:16]);
    d   = f[15:4];
    last_m = f;
    if (!clr_m) return;
    for (int c = 0; c < 4; c++) begin
      if (adr == 15 || adr == c) begin
        if (cmd == 0 || cmd == 2) inreg_m[c] = d;
        if (cmd == 1) begin dac_m[c] = inreg_m[c]; pd_m[c] = 1'b0; end
        if (cmd == 3) begin inreg_m[c] = d; dac_m[c] = d; pd_m[c] = 1'b0; end
        if (cmd == 4) pd_m[c] = 1'b1;
      end
    end
    if (cmd == 2) begin
      for (int c = 0; c < 4; c++) dac_m[c] = inreg_m[c];
      pd_m = 4'h0;
    end
  endtask

  // Clock n bits out MSB first, recording DAC_OUT just before each rising SCK
  task automatic shift_bits(input logic [63:0] f, input int n, output logic [63:0] rb);
    rb = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.SPI_MOSI = f[i];
      wait_cyc(H);
      rb = {rb[62:0], bus.DAC_OUT};
      bus.SPI_SCK = 1'b1;
      wait_cyc(H);
      bus.SPI_SCK = 1'b0;
      sreg_m = {sreg_m[30:0], f[i]};
    end
    wait_cyc(H);
  endtask

  // Full CS-framed transfer; readback checked against the previous shift contents
  task automatic send_frame(input string tag, input logic [63:0] f, input int n);
    logic [63:0] rb;
    logic [31:0] prev;
    prev = sreg_m;
    bus.DAC_CS = 1'b0;
    wait_cyc(H);
    shift_bits(f, n, rb);
    bus.DAC_CS = 1'b1;
    wait_cyc(10);
    if (n == 32) begin
      model_apply(f[31:0]);
      exp_done++;
      check({tag, "/readback"}, rb, {32'h0, prev});
    end else begin
      exp_err++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/dac_value"}, {16'h0, dac_value}, {16'h0, dac_pack()});
    check({tag, "/powerdown"}, {60'h0, dac_powerdown}, {60'h0, pd_m});
    check({tag, "/last_frame"}, {32'h0, last_frame}, {32'h0, last_m});
    check({tag, "/done_count"}, 64'(done_cnt), 64'(exp_done));
    check({tag, "/err_count"}, 64'(err_cnt), 64'(exp_err));
  endtask

  initial begin
    logic [63:0] rb;
    logic [31:0] f;
    logic [3:0]  cmd, adr;
    int          n;

    rst = 1'b1;
    bus.SPI_SCK = 1'b0;
    bus.DAC_CS = 1'b1;
    bus.SPI_MOSI = 1'b0;
    bus.DAC_CLR = 1'b1;
    clr_m = 1'b1;
    exp_done = 0;
    exp_err = 0;
    model_reset();

    // Reset state
    wait_cyc(4);
    check("reset/dac_out", {63'h0, bus.DAC_OUT}, 64'h0);
    check("reset/frame_done", {63'h0, frame_done}, 64'h0);
    check("reset/frame_err", {63'h0, frame_err}, 64'h0);
    rst = 1'b0;
    wait_cyc(5);
    check_all("reset");

    // Write-and-update channel A
    send_frame("wrupd_a", 64'h0030ABC0, 32);
    check_all("wrupd_a");
    check("wrupd_a/chan_a", {52'h0, dac_value[11:0]}, 64'hABC);

    // Write B, then update B with readback of the write frame
    send_frame("write_b", 64'h00015550, 32);
    check_all("write_b");
    send_frame("update_b", 64'h00110000, 32);
    check_all("update_b");
    check("update_b/chan_b", {52'h0, dac_value[23:12]}, 64'h555);

    // Broadcast write-update, then power down channel C
    send_frame("all_7ff", 64'h003F7FF0, 32);
    check_all("all_7ff");
    send_frame("pd_c", 64'h00420000, 32);
    check_all("pd_c");
    check("pd_c/flags", {60'h0, dac_powerdown}, 64'h4);

    // Short and long frames only raise frame_err
    send_frame("short31", 64'h0030_1230 >> 1, 31);
    send_frame("long33", 64'h1_0030_1230, 33);
    check_all("badlen");

    // Clear held low across a write-update of D
    bus.DAC_CLR = 1'b0;
    wait_cyc(5);
    clr_m = 1'b0;
    model_clear_regs();
    check_all("clr_low");
    send_frame("clr_wrupd_d", 64'h00334560, 32);
    check_all("clr_wrupd_d");
    bus.DAC_CLR = 1'b1;
    wait_cyc(5);
    clr_m = 1'b1;
    send_frame("wrupd_d", 64'h00331230, 32);
    check_all("wrupd_d");
    check("wrupd_d/chan_d", {52'h0, dac_value[47:36]}, 64'h123);

    // Reset in the middle of a frame; the frame is lost
    bus.DAC_CS = 1'b0;
    wait_cyc(H);
    shift_bits(64'h0033ABC0 >> 16, 16, rb);
    rst = 1'b1;
    bus.DAC_CS = 1'b1;
    bus.SPI_SCK = 1'b0;
    model_reset();
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(12);
    check_all("midreset");
    send_frame("after_reset", 64'h00330FF0, 32);
    check_all("after_reset");
    check("after_reset/chan_d", {52'h0, dac_value[47:36]}, 64'h0FF);

    // Random frames, mostly well formed, against the model
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 7))
        0: cmd = 4'h0;
        1: cmd = 4'h1;
        2: cmd = 4'h2;
        3: cmd = 4'h3;
        4: cmd = 4'h4;
        5: cmd = 4'h0;
        6: cmd = 4'h3;
        default: cmd = 4'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: adr = 4'h0;
        1: adr = 4'h1;
        2: adr = 4'h2;
        3: adr = 4'h3;
        4: adr = 4'hF;
        default: adr = 4'($urandom);
      endcase
      f = {8'($urandom), cmd, adr, 12'($urandom), 4'($urandom)};
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(29, 35)) : 32;
      send_frame("random", {32'($urandom), f}, n);
      check_all("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
